ctrl_decode_stage: RTL
======================

# ctrl_decode_stage

Registered MIPS control-decode stage sitting between the IF/ID instruction register and the EX stage. It decodes a 32-bit instruction into the control bundle (addu, subu, jr, ori, lw, sw, beq, lui, jal, j, syscall) and holds it in an ID/EX output register with valid/ready handshakes on both sides. It also provides:
- load-use interlock;
- synchronous flush;
- branch-shadow squashing of a configurable number of younger instructions;
- a sticky halt on syscall, which replaces simulation termination.

## Interface
Parameters:
- SHADOW_SLOTS, 1, instructions squashed after a redirect (legal 0..7)
- ALU_OP_W, 4, width of ALU opcode field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- ins  in  32  instruction word
- flush  in  1  synchronous: clear output register
- redirect  in  1  synchronous: EX resolved taken branch/jump; clear output and start shadow
- out_valid  out  1  output bundle valid
- out_ready  in  1  EX accepts bundle
- out_ins  out  32  instruction carried with bundle
- out_jal, out_jr, out_j, out_branch  out  1 each  control-flow flags
- out_memtoreg, out_memread, out_memwrite, out_regwrite, out_alu_src  out  1 each
- out_regdst  out  3  001 rd, 010 rt, 100 r31, 000 none
- out_alu_op  out  ALU_OP_W  ALU operation
- out_wreg  out  5  resolved destination register (0 when out_regwrite=0)
- halted  out  1  sticky; syscall accepted
- illegal  out  1  sticky; see Configuration

## Operation
Decode (opcode = ins[31:26], func = ins[5:0]):

| Instruction | Encoding | Control signals |
|---|---|---|
| addu | 000000/100001 | regdst 001, regwrite, alu 0001, src 1 |
| subu | 000000/100011 | as addu, alu 0010 |
| jr | 000000/001000 | jr, alu 0001, src 1 |
| ori | 001101 | regdst 010, regwrite, alu 0100, src 0 |
| lw | 100011 | memread, memtoreg, regwrite, regdst 010, alu 0001, src 0 |
| sw | 101011 | memwrite, alu 0001, src 0 |
| beq | 000100 | branch, alu 0010, src 1 |
| lui | 001111 | regwrite, regdst 010, alu 0011, src 0 |
| jal | 000011 | jal, regwrite, regdst 100, alu 1001, out_wreg 31 |
| j | 000010 | j, alu 0001 |
| syscall | 000000/001100 | see below |

Unlisted fields are 0.

Register sources:
- rs is used by addu, subu, jr, ori, lw, sw, beq.
- rt is used by addu, subu, sw, beq.

Internal signals:
- advance = !out_valid || out_ready
- hazard = out_valid && out_memread && out_wreg != 0 && in_valid && (incoming rs or rt, when used, == out_wreg)

in_ready:
- in_ready = !halted && !redirect && (shadow_cnt != 0 || (advance && !hazard))

Priority per cycle is reset > redirect > flush > halted > shadow > hazard > normal load.
- redirect: out_valid←0, shadow_cnt←SHADOW_SLOTS, nothing accepted.
- flush: out_valid←0, shadow_cnt unchanged.
- shadow_cnt != 0: each accepted instruction is discarded and shadow_cnt decrements. out_valid←0 if advance.
- hazard && advance: load a bubble (out_valid←0) and hold the instruction.
- normal: when advance, register the decoded bundle on handshake (out_valid←1). When advance without handshake, out_valid←0.
- !advance: the output register holds all fields.
- syscall accepted: halted←1, the instruction is consumed, and no bundle is emitted. The halt persists until reset.

## Timing
- Reset: every output 0 (in_ready recomputes to 1), shadow_cnt 0, halted 0, illegal 0.
- Latency: accepted instruction appears at the output the next edge.
- Throughput: 1 per cycle with out_ready high.
- Load-use: exactly one bubble per dependent pair.
- The output bundle is stable while out_valid && !out_ready.
- Redirect and flush in the same cycle: redirect wins.
- SHADOW_SLOTS=0: redirect clears only.
- shadow_cnt decrements only on handshakes, so gaps in in_valid do not consume slots.
- Reset asserted mid-stall or mid-shadow clears everything immediately (asynchronous).

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode or func on handshake sets illegal and halted (sticky).
  - No bundle is emitted.
- CTRL_ILLEGAL_TRAP_EN not defined:
  - An unknown instruction is consumed as a NOP; out_valid←0 for that slot.
  - illegal is tied to 0.

## Test plan
- Reset, then stream addu $3,$1,$2 (0x00221821) and ori $4,$0,5 (0x34040005) with out_ready=1. Required: bundles on consecutive cycles, out_wreg 3 then 4, alu 0001 then 0100.
- lw $5,0($1) (0x8C250000) followed by addu $6,$5,$2 (0x00A23021). Required: one bubble cycle with in_ready=0, then addu issues. With rs=$7 instead, no bubble.
- jal 0x100 (0x0C000040). Required: out_jal=1, out_regdst=100, out_wreg=31, alu 1001.
- SHADOW_SLOTS=2: pulse redirect, then offer 3 instructions. Required: out_valid=0 for the first two; the third issues.
- Hold out_ready=0 for 4 cycles with valid bundle. Required: fields stable, in_ready=0. Asserting flush then yields out_valid=0 next edge.
- Offer syscall (0x0000000C). Required: halted=1 next edge, in_ready stays 0. With CTRL_ILLEGAL_TRAP_EN, opcode 0x3F sets illegal=1 and halted=1.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage
// Registered MIPS control-decode stage between the IF/ID instruction register
// and EX. Decodes addu, subu, jr, ori, lw, sw, beq, lui, jal, j and syscall
// into a control bundle held in an ID/EX register with valid/ready on both
// sides. Also provides a load-use interlock, a synchronous flush,
// branch-shadow squashing after a redirect, and a sticky halt on syscall.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined     : an unknown instruction on handshake sets illegal and halted
//   not defined : an unknown instruction is consumed as a NOP; illegal is 0
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready/ins instruction handshake and word
//   flush, redirect       synchronous clear / clear-and-start-shadow
//   out_valid/out_ready   bundle handshake toward EX
//   out_*                 registered control bundle, out_ins carries the word
//   halted, illegal       sticky status flags
module ctrl_decode_stage #(
  parameter int SHADOW_SLOTS = 1,
  parameter int ALU_OP_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         ins,
  input  logic                flush,
  input  logic                redirect,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_ins,
  output logic                out_jal,
  output logic                out_jr,
  output logic                out_j,
  output logic                out_branch,
  output logic                out_memtoreg,
  output logic                out_memread,
  output logic                out_memwrite,
  output logic                out_regwrite,
  output logic                out_alu_src,
  output logic [2:0]          out_regdst,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [4:0]          out_wreg,
  output logic                halted,
  output logic                illegal
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam logic [ALU_OP_W-1:0] ALU_NONE = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(4'b0011);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'b0100);
  localparam logic [ALU_OP_W-1:0] ALU_JAL  = ALU_OP_W'(4'b1001);

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_RD   = 3'b001;
  localparam logic [2:0] RD_RT   = 3'b010;
  localparam logic [2:0] RD_R31  = 3'b100;

  localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_SLOTS);

  typedef struct packed {
    logic                jal;
    logic                jr;
    logic                j;
    logic                branch;
    logic                memtoreg;
    logic                memread;
    logic                memwrite;
    logic                regwrite;
    logic                alu_src;
    logic [2:0]          regdst;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          wreg;
    logic [31:0]         ins;
  } bndl_t;

  bndl_t      bndl_q, bndl_d, dec_bndl;
  logic       out_valid_q, out_valid_d;
  logic [2:0] shadow_q, shadow_d;
  logic       halted_q, halted_d;
  logic       dec_known, dec_sys, use_rs, use_rt;
  logic       advance, hazard, accept;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_q, illegal_d;
`endif

  // Combinational decode of the offered instruction into a candidate bundle.
  always_comb begin
    dec_bndl        = '0;
    dec_bndl.ins    = ins;
    dec_bndl.regdst = RD_NONE;
    dec_bndl.alu_op = ALU_NONE;
    dec_known       = 1'b1;
    dec_sys         = 1'b0;
    use_rs          = 1'b0;
    use_rt          = 1'b0;
    case (ins[31:26])
      OP_SPECIAL: begin
        case (ins[5:0])
          FN_ADDU, FN_SUBU: begin
            dec_bndl.regdst   = RD_RD;
            dec_bndl.regwrite = 1'b1;
            dec_bndl.alu_src  = 1'b1;
            dec_bndl.alu_op   = (ins[5:0] == FN_ADDU) ? ALU_ADD : ALU_SUB;
            use_rs            = 1'b1;
            use_rt            = 1'b1;
          end
          FN_JR: begin
            dec_bndl.jr      = 1'b1;
            dec_bndl.alu_op  = ALU_ADD;
            dec_bndl.alu_src = 1'b1;
            use_rs           = 1'b1;
          end
          FN_SYSCALL: dec_sys = 1'b1;
          default:    dec_known = 1'b0;
        endcase
      end
      OP_ORI: begin
        dec_bndl.regdst   = RD_RT;
        dec_bndl.regwrite = 1'b1;
        dec_bndl.alu_op   = ALU_OR;
        use_rs            = 1'b1;
      end
      OP_LW: begin
        dec_bndl.memread  = 1'b1;
        dec_bndl.memtoreg = 1'b1;
        dec_bndl.regwrite = 1'b1;
        dec_bndl.regdst   = RD_RT;
        dec_bndl.alu_op   = ALU_ADD;
        use_rs            = 1'b1;
      end
      OP_SW: begin
        dec_bndl.memwrite = 1'b1;
        dec_bndl.alu_op   = ALU_ADD;
        use_rs            = 1'b1;
        use_rt            = 1'b1;
      end
      OP_BEQ: begin
        dec_bndl.branch  = 1'b1;
        dec_bndl.alu_op  = ALU_SUB;
        dec_bndl.alu_src = 1'b1;
        use_rs           = 1'b1;
        use_rt           = 1'b1;
      end
      OP_LUI: begin
        dec_bndl.regwrite = 1'b1;
        dec_bndl.regdst   = RD_RT;
        dec_bndl.alu_op   = ALU_LUI;
      end
      OP_JAL: begin
        dec_bndl.jal      = 1'b1;
        dec_bndl.regwrite = 1'b1;
        dec_bndl.regdst   = RD_R31;
        dec_bndl.alu_op   = ALU_JAL;
      end
      OP_J: begin
        dec_bndl.j      = 1'b1;
        dec_bndl.alu_op = ALU_ADD;
      end
      default: dec_known = 1'b0;
    endcase
    // Destination resolved here so the hazard compare needs no mux later.
    case (dec_bndl.regdst)
      RD_RD:   dec_bndl.wreg = ins[15:11];
      RD_RT:   dec_bndl.wreg = ins[20:16];
      RD_R31:  dec_bndl.wreg = 5'd31;
      default: dec_bndl.wreg = 5'd0;
    endcase
    if (!dec_bndl.regwrite) begin
      dec_bndl.wreg = 5'd0;
    end else begin
      dec_bndl.wreg = dec_bndl.wreg;
    end
  end

  assign advance = !out_valid_q || out_ready;
  // Load-use: the load in the output register writes a register the
  // incoming instruction reads; $0 never creates a dependency.
  assign hazard  = out_valid_q && bndl_q.memread && (bndl_q.wreg != 5'd0) && in_valid &&
                   ((use_rs && (ins[25:21] == bndl_q.wreg)) ||
                    (use_rt && (ins[20:16] == bndl_q.wreg)));
  // Shadow slots accept regardless of downstream state since they are dropped.
  assign in_ready = !halted_q && !redirect && ((shadow_q != 3'd0) || (advance && !hazard));
  assign accept   = in_valid && in_ready;

  // Next-state selection in priority order: redirect, flush, halt, shadow, load.
  always_comb begin
    bndl_d      = bndl_q;
    out_valid_d = out_valid_q;
    shadow_d    = shadow_q;
    halted_d    = halted_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    if (redirect) begin
      out_valid_d = 1'b0;
      shadow_d    = SHADOW_INIT;
    end else if (flush) begin
      out_valid_d = 1'b0;
    end else if (halted_q) begin
      out_valid_d = advance ? 1'b0 : out_valid_q;
    end else if (shadow_q != 3'd0) begin
      shadow_d    = accept ? (shadow_q - 3'd1) : shadow_q;
      out_valid_d = advance ? 1'b0 : out_valid_q;
    end else if (advance) begin
      // A hazard blocks accept, so this path also loads the bubble.
      out_valid_d = 1'b0;
      if (accept && dec_sys) begin
        halted_d = 1'b1;
      end else if (accept && !dec_known) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = 1'b1;
        halted_d  = 1'b1;
`else
        halted_d  = halted_q;
`endif
      end else if (accept) begin
        out_valid_d = 1'b1;
        bndl_d      = dec_bndl;
      end else begin
        bndl_d = bndl_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bndl_q      <= '0;
      out_valid_q <= 1'b0;
      shadow_q    <= 3'd0;
      halted_q    <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      bndl_q      <= bndl_d;
      out_valid_q <= out_valid_d;
      shadow_q    <= shadow_d;
      halted_q    <= halted_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_ins      = bndl_q.ins;
  assign out_jal      = bndl_q.jal;
  assign out_jr       = bndl_q.jr;
  assign out_j        = bndl_q.j;
  assign out_branch   = bndl_q.branch;
  assign out_memtoreg = bndl_q.memtoreg;
  assign out_memread  = bndl_q.memread;
  assign out_memwrite = bndl_q.memwrite;
  assign out_regwrite = bndl_q.regwrite;
  assign out_alu_src  = bndl_q.alu_src;
  assign out_regdst   = bndl_q.regdst;
  assign out_alu_op   = bndl_q.alu_op;
  assign out_wreg     = bndl_q.wreg;
  assign halted       = halted_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal      = illegal_q;
`else
  assign illegal      = 1'b0;
`endif

endmodule
